// File: rtl/bitty_test_monitor_pkg.sv
// Shared types and default register map for the bitty self-check monitor.
package bitty_test_monitor_pkg;

    // Monitor FSM states; the enum takes over from the old `define encodings.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4,
        ST_TOUT   = 3'd5
    } mon_state_t;

    // Default register indices used by the bitty test firmware.
    localparam int unsigned DEF_DONE_REG = 26;
    localparam int unsigned DEF_PASS_REG = 27;
    localparam int unsigned DEF_ID_REG   = 3;

    // Tallies are fixed-width regardless of XLEN.
    localparam int unsigned TALLY_W = 16;

    // True for the three terminal verdict states.
    function automatic logic is_verdict(input mon_state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TOUT);
    endfunction

endpackage

// File: rtl/bitty_test_monitor_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for cycle and run tallies.
module bitty_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear dominates increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/bitty_test_monitor.sv
// Register-file write snooper that turns done/pass/id register writes into a
// sticky pass/fail/timeout verdict with per-run cycle count and run tallies.
module bitty_test_monitor
    import bitty_test_monitor_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DONE_REG    = DEF_DONE_REG,
    parameter int unsigned PASS_REG    = DEF_PASS_REG,
    parameter int unsigned ID_REG      = DEF_ID_REG,
    parameter int unsigned DONE_VAL    = 1,
    parameter int unsigned PASS_VAL    = 1,
    parameter int unsigned SETTLE_CYC  = 5,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 wr_en,
    input  logic [4:0]           wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    output logic                 busy,
    output logic                 test_done,
    output logic                 test_pass,
    output logic                 test_fail,
    output logic                 test_tout,
    output logic [XLEN-1:0]      fail_id,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [TALLY_W-1:0]   pass_tally,
    output logic [TALLY_W-1:0]   fail_tally
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC) + 1;
    localparam int unsigned TOUT_W   = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [4:0]          DONE_IDX    = 5'(DONE_REG);
    localparam logic [4:0]          PASS_IDX    = 5'(PASS_REG);
    localparam logic [4:0]          ID_IDX      = 5'(ID_REG);
    localparam logic [XLEN-1:0]     DONE_V      = XLEN'(DONE_VAL);
    localparam logic [XLEN-1:0]     PASS_V      = XLEN'(PASS_VAL);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic                TOUT_EN     = (TIMEOUT_CYC != 0);
    localparam logic [TOUT_W-1:0]   TOUT_LAST   = TOUT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    mon_state_t          state, state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [TOUT_W-1:0]   tout_cnt;
    logic [XLEN-1:0]     pass_sh, id_sh;

    logic            in_run, in_settle;
    logic            addr_live;
    logic            done_hit, tout_hit;
    logic [XLEN-1:0] pass_wt, id_wt;
    logic            go_run, go_settle, enter_verdict;
    logic            pass_inc, fail_inc;

    assign in_run    = (state == ST_RUN);
    assign in_settle = (state == ST_SETTLE);
    assign busy      = in_run || in_settle;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; shadow values are taken write-through so a write in
    // the sampling cycle is already visible to the verdict.
    always_comb begin
        state_nxt = state;
        addr_live = wr_en && (wr_addr != 5'd0);
        pass_wt   = (addr_live && (wr_addr == PASS_IDX)) ? wr_data : pass_sh;
        id_wt     = (addr_live && (wr_addr == ID_IDX))   ? wr_data : id_sh;
        done_hit  = addr_live && (wr_addr == DONE_IDX) && (wr_data == DONE_V);
        tout_hit  = TOUT_EN && (tout_cnt == TOUT_LAST);

        case (state)
            ST_IDLE, ST_PASS, ST_FAIL, ST_TOUT: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done_hit) begin
                    state_nxt = ST_SETTLE;
                end else if (tout_hit) begin
                    state_nxt = ST_TOUT;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = (pass_wt == PASS_V) ? ST_PASS : ST_FAIL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        go_run        = !busy && (state_nxt == ST_RUN);
        go_settle     = in_run && (state_nxt == ST_SETTLE);
        enter_verdict = busy && is_verdict(state_nxt);
        pass_inc      = enter_verdict && (state_nxt == ST_PASS);
        fail_inc      = enter_verdict && (state_nxt != ST_PASS);
    end

    // Settle/timeout counters, register shadows and sticky verdict outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            tout_cnt   <= '0;
            pass_sh    <= '0;
            id_sh      <= '0;
            test_done  <= 1'b0;
            test_pass  <= 1'b0;
            test_fail  <= 1'b0;
            test_tout  <= 1'b0;
            fail_id    <= '0;
        end else if (go_run) begin
            settle_cnt <= '0;
            tout_cnt   <= '0;
            pass_sh    <= '0;
            id_sh      <= '0;
            test_done  <= 1'b0;
            test_pass  <= 1'b0;
            test_fail  <= 1'b0;
            test_tout  <= 1'b0;
            fail_id    <= '0;
        end else begin
            if (busy) begin
                pass_sh <= pass_wt;
                id_sh   <= id_wt;
            end
            if (go_settle) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (in_settle && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
            if (in_run && TOUT_EN) begin
                tout_cnt <= tout_cnt + TOUT_W'(1);
            end
            if (enter_verdict) begin
                test_done <= 1'b1;
                test_pass <= (state_nxt == ST_PASS);
                test_fail <= (state_nxt == ST_FAIL);
                test_tout <= (state_nxt == ST_TOUT);
                fail_id   <= id_wt;
            end
        end
    end

    bitty_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (go_run),
        .inc (busy),
        .cnt (cycle_cnt)
    );

    bitty_sat_cnt #(.W(TALLY_W)) u_pass_tally (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (pass_inc),
        .cnt (pass_tally)
    );

    bitty_sat_cnt #(.W(TALLY_W)) u_fail_tally (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (fail_inc),
        .cnt (fail_tally)
    );

endmodule

// File: tb/tb_bitty_test_monitor.sv
// Directed bench for bitty_test_monitor with hand-computed expectations.
module tb_bitty_test_monitor;

    logic        clk = 1'b0;
    logic        rst, start, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, test_done, test_pass, test_fail, test_tout;
    logic [31:0] fail_id, cycle_cnt;
    logic [15:0] pass_tally, fail_tally;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    bitty_test_monitor #(
        .XLEN        (32),
        .SETTLE_CYC  (5),
        .TIMEOUT_CYC (50),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .test_fail  (test_fail),
        .test_tout  (test_tout),
        .fail_id    (fail_id),
        .cycle_cnt  (cycle_cnt),
        .pass_tally (pass_tally),
        .fail_tally (fail_tally)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=expired expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(test_done), 0);
        check("rst_tally", 32'({pass_tally, fail_tally}), 0);

        // 1: pass run, done write at cycle N -> verdict visible at N+6
        pulse_start();
        check("p_busy", 32'(busy), 1);
        wr(5'd27, 1);
        wr(5'd3, 7);
        wr(5'd26, 1);
        tick(4);
        check("p_early", 32'(test_done), 0);
        tick(1);
        check("p_done", 32'(test_done), 1);
        check("p_pass", 32'(test_pass), 1);
        check("p_fail", 32'(test_fail), 0);
        check("p_ptally", 32'(pass_tally), 1);
        check("p_ftally", 32'(fail_tally), 0);
        check("p_cyc", cycle_cnt, 8);
        check("p_busy_off", 32'(busy), 0);

        // 2/6: rerun that fails; flags reflect only this run
        pulse_start();
        check("f_cleared", 32'(test_done), 0);
        wr(5'd3, 12);
        wr(5'd27, 0);
        wr(5'd26, 1);
        tick(5);
        check("f_fail", 32'(test_fail), 1);
        check("f_pass", 32'(test_pass), 0);
        check("f_id", fail_id, 12);
        check("f_ftally", 32'(fail_tally), 1);
        check("f_ptally", 32'(pass_tally), 1);

        // 4: non-DONE_VAL write to x26 is ignored; pass written in SETTLE cycle 3
        pulse_start();
        wr(5'd27, 0);
        wr(5'd26, 2);
        check("r_nodone", 32'(busy), 1);
        wr(5'd26, 1);
        tick(2);
        wr(5'd27, 1);
        tick(1);
        check("r_early", 32'(test_done), 0);
        tick(1);
        check("r_pass", 32'(test_pass), 1);
        check("r_ptally", 32'(pass_tally), 2);

        // write-through: pass flag written in the last SETTLE cycle still counts
        pulse_start();
        wr(5'd26, 1);
        tick(4);
        wr(5'd27, 1);
        check("wt_pass", 32'(test_pass), 1);
        check("wt_cyc", cycle_cnt, 6);

        // 5: x0 write, ignored start in RUN, done on the timeout expiry cycle
        pulse_start();
        wr(5'd0, 1);
        pulse_start();
        tick(47);
        wr(5'd26, 1);
        check("c_race_busy", 32'(busy), 1);
        check("c_race_tout", 32'(test_tout), 0);
        tick(5);
        check("c_fail", 32'(test_fail), 1);
        check("c_id", fail_id, 0);
        check("c_cyc", cycle_cnt, 55);
        check("c_ftally", 32'(fail_tally), 2);

        // 3: timeout after exactly 50 RUN cycles
        pulse_start();
        wr(5'd3, 9);
        tick(48);
        check("t_early", 32'(test_done), 0);
        tick(1);
        check("t_tout", 32'(test_tout), 1);
        check("t_done", 32'(test_done), 1);
        check("t_cyc", cycle_cnt, 50);
        check("t_id", fail_id, 9);
        check("t_ftally", 32'(fail_tally), 3);
        tick(3);
        check("t_hold", 32'({test_tout, cycle_cnt[30:0]}), {1'b1, 31'd50});

        // 6: reset mid-RUN clears everything including tallies
        pulse_start();
        wr(5'd27, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("x_busy", 32'(busy), 0);
        check("x_flags", 32'({test_done, test_pass, test_fail, test_tout}), 0);
        check("x_id", fail_id, 0);
        check("x_cyc", cycle_cnt, 0);
        check("x_ptally", 32'(pass_tally), 0);
        check("x_ftally", 32'(fail_tally), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
